// File: rtl/serial_parity_checker.sv
// Multi-channel serial parity checker.
// Each lane frames DATA_BITS data bits plus one parity bit.
module serial_parity_checker #(
  parameter int CHANNELS   = 4,
  parameter int DATA_BITS  = 8,
  parameter bit ODD_PARITY = 1'b0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CHANNELS-1:0]             x,
  input  logic [CHANNELS-1:0]             x_valid,
  input  logic [CHANNELS-1:0]             sof,
  input  logic                            clr_cnt,
  output logic [CHANNELS-1:0]             z,
  output logic [CHANNELS-1:0]             busy,
  output logic [CHANNELS-1:0]             frame_done,
  output logic [CHANNELS-1:0]             parity_err,
  output logic [CHANNELS-1:0]             frame_abort,
  output logic [CHANNELS*ERR_CNT_W-1:0]   err_cnt
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [ERR_CNT_W-1:0] SAT = '1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY
  } state_e;

  state_e              state_q [CHANNELS];
  state_e              state_d [CHANNELS];
  logic [CW-1:0]       cnt_q   [CHANNELS];
  logic [CW-1:0]       cnt_d   [CHANNELS];
  logic [ERR_CNT_W-1:0] ecnt_q [CHANNELS];
  logic [ERR_CNT_W-1:0] ecnt_d [CHANNELS];
  logic [CHANNELS-1:0] z_q, z_d;
  logic [CHANNELS-1:0] done_q, done_d;
  logic [CHANNELS-1:0] err_q, err_d;
  logic [CHANNELS-1:0] abort_q, abort_d;

  // State, running parity, pulses and counters per lane.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        ecnt_q[i]  <= '0;
      end
      z_q     <= '0;
      done_q  <= '0;
      err_q   <= '0;
      abort_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        ecnt_q[i]  <= ecnt_d[i];
      end
      z_q     <= z_d;
      done_q  <= done_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  // Next-state: a sof mid-frame or any bit in IDLE opens a new frame.
  always_comb begin
    z_d     = z_q;
    done_d  = '0;
    err_d   = '0;
    abort_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      ecnt_d[i]  = ecnt_q[i];
      if (x_valid[i]) begin
        unique case (state_q[i])
          DATA: begin
            if (!sof[i]) begin
              z_d[i]   = z_q[i] ^ x[i];
              cnt_d[i] = cnt_q[i] + ONE;
              if (cnt_q[i] + ONE == LAST) begin
                state_d[i] = PARITY;
              end
            end
          end
          PARITY: begin
            if (!sof[i]) begin
              done_d[i]  = 1'b1;
              err_d[i]   = (z_q[i] ^ x[i]) != ODD_PARITY;
              state_d[i] = IDLE;
              cnt_d[i]   = '0;
              if (err_d[i] && ecnt_q[i] != SAT) begin
                ecnt_d[i] = ecnt_q[i] + 1'b1;
              end
            end
          end
          default: ;
        endcase
        if (state_q[i] == IDLE || sof[i]) begin
          abort_d[i] = state_q[i] != IDLE;
          z_d[i]     = x[i];
          cnt_d[i]   = ONE;
          state_d[i] = (DATA_BITS == 1) ? PARITY : DATA;
        end
      end
      if (clr_cnt) begin
        ecnt_d[i] = '0;
      end
    end
  end

  // Output mapping; busy covers both DATA and PARITY.
  always_comb begin
    busy    = '0;
    err_cnt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      busy[i] = state_q[i] != IDLE;
      err_cnt[i*ERR_CNT_W +: ERR_CNT_W] = ecnt_q[i];
    end
  end

  assign z           = z_q;
  assign frame_done  = done_q;
  assign parity_err  = err_q;
  assign frame_abort = abort_q;

endmodule
